// File: rtl/microwave_ctrl_pkg.sv
// Shared definitions for the microwave timer sequencer: state encodings and BCD helpers.
// The display mux imports the same state encodings.
package microwave_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StEntry = 3'd1,
        StCook  = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [3:0] code);
        return code <= BCD_MAX;
    endfunction

endpackage

// File: rtl/microwave_ctrl_if.sv
// Keypad/door/prescaler inputs and timer/magnetron outputs of the microwave sequencer.
// The slave modport is the controller; the master modport drives its inputs.
interface microwave_ctrl_if;

    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       stop;
    logic       clear;
    logic       door_closed;
    logic       tick;
    logic       timer_zero;

    logic       timer_loadn;
    logic       timer_clrn;
    logic       timer_enn;
    logic [3:0] timer_data;
    logic       mag_on;
    logic       done_alarm;
    logic [2:0] state_o;

    modport master (
        output key_valid, key_code, start, stop, clear, door_closed, tick, timer_zero,
        input  timer_loadn, timer_clrn, timer_enn, timer_data, mag_on, done_alarm, state_o
    );

    modport slave (
        input  key_valid, key_code, start, stop, clear, door_closed, tick, timer_zero,
        output timer_loadn, timer_clrn, timer_enn, timer_data, mag_on, done_alarm, state_o
    );

endinterface

// File: rtl/microwave_ctrl.sv
// Sequencing FSM for the 3-digit BCD countdown timer: digit entry, cook/pause/abort,
// 1 Hz decrement gating, magnetron enable and end-of-cook alarm. All outputs registered.
module microwave_ctrl
    import microwave_ctrl_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 3,
    parameter int unsigned BEEP_TICKS = 3
) (
    input logic             clk,
    input logic             clr,
    microwave_ctrl_if.slave bus
);

    localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
    localparam int unsigned BeepW = $clog2(BEEP_TICKS + 1);

    state_t             state_q, state_d;
    logic [CntW-1:0]    digit_cnt_q, digit_cnt_d;
    logic [BeepW-1:0]   beep_cnt_q, beep_cnt_d;
    logic               loadn_q, loadn_d;
    logic               clrn_q, clrn_d;
    logic               enn_q, enn_d;
    logic [3:0]         data_q, data_d;
    logic               mag_on_q, mag_on_d;
    logic               alarm_q, alarm_d;
    logic               key_ok;

    assign key_ok = bus.key_valid && is_bcd(bus.key_code);

    // Each branch chain follows the event priority: clear > stop > door > zero > start > key > tick.
    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        beep_cnt_d  = beep_cnt_q;
        loadn_d     = 1'b1;
        clrn_d      = 1'b1;
        enn_d       = 1'b1;
        data_d      = data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.clear) begin
                    clrn_d = 1'b0;
                end else if (key_ok) begin
                    loadn_d     = 1'b0;
                    data_d      = bus.key_code;
                    digit_cnt_d = CntW'(1);
                    state_d     = StEntry;
                end
            end
            StEntry: begin
                if (bus.clear || bus.stop) begin
                    clrn_d  = 1'b0;
                    state_d = StIdle;
                end else if (bus.start) begin
                    if (bus.door_closed && !bus.timer_zero) begin
                        state_d = StCook;
                    end
                end else if (key_ok && (digit_cnt_q < CntW'(MAX_DIGITS))) begin
                    loadn_d     = 1'b0;
                    data_d      = bus.key_code;
                    digit_cnt_d = digit_cnt_q + CntW'(1);
                end
            end
            StCook: begin
                if (bus.clear) begin
                    clrn_d  = 1'b0;
                    state_d = StIdle;
                end else if (bus.stop || !bus.door_closed) begin
                    state_d = StPause;
                end else if (bus.timer_zero) begin
                    // Never decrement at 0:00, so the timer cannot wrap to 9:59.
                    state_d    = StDone;
                    beep_cnt_d = '0;
                end else if (bus.tick) begin
                    enn_d = 1'b0;
                end
            end
            StPause: begin
                if (bus.clear || bus.stop) begin
                    clrn_d  = 1'b0;
                    state_d = StIdle;
                end else if (bus.start && bus.door_closed) begin
                    state_d = StCook;
                end
            end
            StDone: begin
                if (bus.clear) begin
                    clrn_d  = 1'b0;
                    state_d = StIdle;
                end else if (bus.stop || bus.start || bus.key_valid) begin
                    state_d = StIdle;
                end else if (bus.tick) begin
                    if (beep_cnt_q == BeepW'(BEEP_TICKS - 1)) begin
                        state_d = StIdle;
                    end else begin
                        beep_cnt_d = beep_cnt_q + BeepW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d == StIdle) begin
            digit_cnt_d = '0;
            beep_cnt_d  = '0;
        end

        mag_on_d = (state_d == StCook);
        alarm_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= StIdle;
            digit_cnt_q <= '0;
            beep_cnt_q  <= '0;
            loadn_q     <= 1'b1;
            clrn_q      <= 1'b0;
            enn_q       <= 1'b1;
            data_q      <= 4'd0;
            mag_on_q    <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            beep_cnt_q  <= beep_cnt_d;
            loadn_q     <= loadn_d;
            clrn_q      <= clrn_d;
            enn_q       <= enn_d;
            data_q      <= data_d;
            mag_on_q    <= mag_on_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.timer_loadn = loadn_q;
    assign bus.timer_clrn  = clrn_q;
    assign bus.timer_enn   = enn_q;
    assign bus.timer_data  = data_q;
    assign bus.mag_on      = mag_on_q;
    assign bus.done_alarm  = alarm_q;
    assign bus.state_o     = state_q;

endmodule
